key_extract_shift: RTL and testbench

Parser stage directly downstream of the type-lookup stage: takes the packet head window together with that stage's per-beat result (key offsets, head shift, meta shift), extracts the selected 16-bit key fields into the metadata vector, and shifts the head window past the parsed header for the next parser layer. It is a two-stage valid/ready pipeline with full throughput and backpressure.

---
 rtl/parser_pkg.sv | 16 +
 rtl/key_field_mux.sv | 39 +++
 rtl/key_extract_shift.sv | 124 ++++++++++++
 tb/tb_key_extract_shift.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/parser_pkg.sv
// Shared parser constants and the per-field key offset type from the type-lookup stage.
package parser_pkg;

   localparam int unsigned KEY_FILED_NUM    = 4;
   localparam int unsigned KEY_OFFSET_WIDTH = 6;
   localparam int unsigned HEAD_SHIFT_WIDTH = 7;
   localparam int unsigned META_SHIFT_WIDTH = 5;
   localparam int unsigned KEY_FIELD_WIDTH  = 16;

   // Top bit of the packed value is the field-valid flag.
   typedef struct packed {
      logic                        vld;
      logic [KEY_OFFSET_WIDTH-1:0] off;
   } key_offset_t;

endpackage

// File: rtl/key_field_mux.sv
// Selects one big-endian key field from the head window at a byte offset.
// OFFSET_CHECK_EN: offsets past HEAD_BYTES-2 yield 0 and flag o_err instead of wrapping.
module key_field_mux
   import parser_pkg::*;
#(
   parameter int HEAD_WIDTH  = 512,
   parameter int FIELD_WIDTH = 16
) (
   input  logic [HEAD_WIDTH-1:0]  i_head,
   input  key_offset_t            i_key,
   output logic [FIELD_WIDTH-1:0] o_field,
   output logic                   o_err
);

   localparam int unsigned HEAD_BYTES = HEAD_WIDTH / 8;

   int unsigned           sh;
   logic [HEAD_WIDTH-1:0] rot;

   always_comb begin
      sh = (32'(i_key.off) % HEAD_BYTES) * 8;
      // Rotate so the addressed byte lands at byte 0; the following byte wraps to byte 0 of head.
      rot = (i_head << sh) | (i_head >> (HEAD_WIDTH - sh));
      o_field = '0;
      o_err   = 1'b0;
      if (i_key.vld) begin
`ifdef OFFSET_CHECK_EN
         if (32'(i_key.off) > HEAD_BYTES - 2) begin
            o_err = 1'b1;
         end else begin
            o_field = rot[HEAD_WIDTH-1 -: FIELD_WIDTH];
         end
`else
         o_field = rot[HEAD_WIDTH-1 -: FIELD_WIDTH];
`endif
      end
   end

endmodule

// File: rtl/key_extract_shift.sv
// Two-stage key extraction and head/meta shift stage with valid/ready backpressure.
// OFFSET_CHECK_EN enables key offset range checking (o_err); otherwise o_err stays 0.
module key_extract_shift #(
   parameter int HEAD_WIDTH      = 512,
   parameter int META_WIDTH      = 256,
   parameter int KEY_FIELD_WIDTH = 16
) (
   input  logic                                                   i_clk,
   input  logic                                                   i_rst,
   input  logic                                                   i_valid,
   output logic                                                   o_ready,
   input  logic [HEAD_WIDTH-1:0]                                  i_head,
   input  logic [META_WIDTH-1:0]                                  i_meta,
   input  parser_pkg::key_offset_t [parser_pkg::KEY_FILED_NUM-1:0] i_keyOffset,
   input  logic [parser_pkg::HEAD_SHIFT_WIDTH-1:0]                i_headShift,
   input  logic [parser_pkg::META_SHIFT_WIDTH-1:0]                i_metaShift,
   output logic                                                   o_valid,
   input  logic                                                   i_ready,
   output logic [HEAD_WIDTH-1:0]                                  o_head,
   output logic [META_WIDTH-1:0]                                  o_meta,
   output logic                                                   o_err
);

   localparam int unsigned HEAD_BYTES = HEAD_WIDTH / 8;
   localparam int unsigned NUM_KEYS   = parser_pkg::KEY_FILED_NUM;

   logic                                           s1_valid_q;
   logic [HEAD_WIDTH-1:0]                          s1_head_q;
   logic [META_WIDTH-1:0]                          s1_meta_q;
   parser_pkg::key_offset_t [NUM_KEYS-1:0]         s1_key_q;
   logic [parser_pkg::HEAD_SHIFT_WIDTH-1:0]        s1_hshift_q;
   logic [parser_pkg::META_SHIFT_WIDTH-1:0]        s1_mshift_q;

   logic                                           s2_valid_q;
   logic [HEAD_WIDTH-1:0]                          s2_head_q;
   logic [META_WIDTH-1:0]                          s2_meta_q;
   logic                                           s2_err_q;

   logic                                           s1_adv;
   logic                                           accept;
   logic [NUM_KEYS-1:0][KEY_FIELD_WIDTH-1:0]       field;
   logic [NUM_KEYS-1:0]                            field_err;
   logic [HEAD_WIDTH-1:0]                          head_d;
   logic [META_WIDTH-1:0]                          meta_d;
   logic                                           err_d;

   assign s1_adv  = ~s2_valid_q | i_ready;
   assign o_ready = ~s1_valid_q | s1_adv;
   assign accept  = i_valid & o_ready;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         s1_valid_q  <= 1'b0;
         s1_head_q   <= '0;
         s1_meta_q   <= '0;
         s1_key_q    <= '0;
         s1_hshift_q <= '0;
         s1_mshift_q <= '0;
      end else begin
         if (o_ready) begin
            s1_valid_q <= i_valid;
         end
         if (accept) begin
            s1_head_q   <= i_head;
            s1_meta_q   <= i_meta;
            s1_key_q    <= i_keyOffset;
            s1_hshift_q <= i_headShift;
            s1_mshift_q <= i_metaShift;
         end
      end
   end

   for (genvar j = 0; j < NUM_KEYS; j++) begin : g_key
      key_field_mux #(
         .HEAD_WIDTH  (HEAD_WIDTH),
         .FIELD_WIDTH (KEY_FIELD_WIDTH)
      ) u_mux (
         .i_head  (s1_head_q),
         .i_key   (s1_key_q[j]),
         .o_field (field[j]),
         .o_err   (field_err[j])
      );
   end

   always_comb begin
      head_d = '0;
      if (32'(s1_hshift_q) < HEAD_BYTES) begin
         head_d = s1_head_q << (32'(s1_hshift_q) * 8);
      end
      meta_d = '0;
      if (32'(s1_mshift_q) * KEY_FIELD_WIDTH < META_WIDTH) begin
         meta_d = s1_meta_q << (32'(s1_mshift_q) * KEY_FIELD_WIDTH);
      end
      for (int j = 0; j < NUM_KEYS; j++) begin
         meta_d[KEY_FIELD_WIDTH*j +: KEY_FIELD_WIDTH] =
            meta_d[KEY_FIELD_WIDTH*j +: KEY_FIELD_WIDTH] | field[j];
      end
      err_d = |field_err;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         s2_valid_q <= 1'b0;
         s2_head_q  <= '0;
         s2_meta_q  <= '0;
         s2_err_q   <= 1'b0;
      end else begin
         if (s1_adv) begin
            s2_valid_q <= s1_valid_q;
         end
         if (s1_adv & s1_valid_q) begin
            s2_head_q <= head_d;
            s2_meta_q <= meta_d;
            s2_err_q  <= err_d;
         end
      end
   end

   assign o_valid = s2_valid_q;
   assign o_head  = s2_head_q;
   assign o_meta  = s2_meta_q;
   assign o_err   = s2_err_q;

endmodule

// File: tb/tb_key_extract_shift.sv
// Directed bench for key_extract_shift; expected values follow OFFSET_CHECK_EN when defined.
module tb_key_extract_shift;
   import parser_pkg::*;

   localparam int HW = 512;
   localparam int MW = 256;

   logic                                  i_clk = 1'b0;
   logic                                  i_rst;
   logic                                  i_valid;
   logic                                  o_ready;
   logic [HW-1:0]                         i_head;
   logic [MW-1:0]                         i_meta;
   key_offset_t [KEY_FILED_NUM-1:0]       i_keyOffset;
   logic [HEAD_SHIFT_WIDTH-1:0]           i_headShift;
   logic [META_SHIFT_WIDTH-1:0]           i_metaShift;
   logic                                  o_valid;
   logic                                  i_ready;
   logic [HW-1:0]                         o_head;
   logic [MW-1:0]                         o_meta;
   logic                                  o_err;

   int checks = 0;
   int errors = 0;

   key_extract_shift #(
      .HEAD_WIDTH      (HW),
      .META_WIDTH      (MW),
      .KEY_FIELD_WIDTH (16)
   ) dut (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_valid     (i_valid),
      .o_ready     (o_ready),
      .i_head      (i_head),
      .i_meta      (i_meta),
      .i_keyOffset (i_keyOffset),
      .i_headShift (i_headShift),
      .i_metaShift (i_metaShift),
      .o_valid     (o_valid),
      .i_ready     (i_ready),
      .o_head      (o_head),
      .o_meta      (o_meta),
      .o_err       (o_err)
   );

   always #5 i_clk = ~i_clk;

   // Head byte i holds base+i.
   function automatic logic [HW-1:0] mk_head(input logic [7:0] base);
      logic [HW-1:0] h = '0;
      for (int i = 0; i < 64; i++) h[HW-1-8*i -: 8] = base + 8'(i);
      return h;
   endfunction

   function automatic logic [HW-1:0] exp_head(input logic [7:0] base, input int sh);
      logic [HW-1:0] h = '0;
      for (int i = 0; i < 64; i++) if (i + sh < 64) h[HW-1-8*i -: 8] = base + 8'(i + sh);
      return h;
   endfunction

   function automatic logic [MW-1:0] fld(input logic [7:0] base, input int off);
      logic [7:0] b0 = base + 8'(off);
      logic [7:0] b1 = base + 8'(off + 1);
      return MW'({b0, b1});
   endfunction

   function automatic key_offset_t key(input logic v, input int off);
      return key_offset_t'({v, 6'(off)});
   endfunction

   task automatic chk(input string tag, input logic [HW-1:0] obs, input logic [HW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic set_beat(input logic [7:0] base, input key_offset_t k0, input key_offset_t k1,
                           input key_offset_t k2, input key_offset_t k3, input int hs,
                           input int ms, input logic [MW-1:0] meta);
      i_head         = mk_head(base);
      i_keyOffset[0] = k0;
      i_keyOffset[1] = k1;
      i_keyOffset[2] = k2;
      i_keyOffset[3] = k3;
      i_headShift    = HEAD_SHIFT_WIDTH'(hs);
      i_metaShift    = META_SHIFT_WIDTH'(ms);
      i_meta         = meta;
   endtask

   initial begin
      i_rst   = 1'b1;
      i_valid = 1'b0;
      i_ready = 1'b1;
      set_beat(8'h00, '0, '0, '0, '0, 0, 0, '0);
      #3;
      chk("rst_valid", o_valid, 1'b0);
      chk("rst_ready", o_ready, 1'b1);
      chk("rst_head", o_head, '0);
      chk("rst_meta", o_meta, '0);
      chk("rst_err", o_err, 1'b0);
      @(negedge i_clk);
      i_rst = 1'b0;
      tick();

      // Basic beat and 2-cycle latency.
      set_beat(8'h00, key(1, 12), '0, '0, '0, 14, 1, '0);
      i_valid = 1'b1;
      chk("t1_ready", o_ready, 1'b1);
      tick();
      i_valid = 1'b0;
      chk("t1_lat1", o_valid, 1'b0);
      tick();
      chk("t1_valid", o_valid, 1'b1);
      chk("t1_meta", o_meta, 256'h0C0D);
      chk("t1_head", o_head, exp_head(8'h00, 14));
      chk("t1_err", o_err, 1'b0);
      tick();
      chk("t1_drain", o_valid, 1'b0);

      // Eight back-to-back beats at full rate.
      for (int c = 0; c <= 8; c++) begin
         if (c < 8) begin
            set_beat(8'(8 * c), key(1, c), '0, '0, '0, c, 0, MW'(c) << 32);
            i_valid = 1'b1;
         end else begin
            i_valid = 1'b0;
         end
         tick();
         if (c >= 1) begin
            chk("t2_valid", o_valid, 1'b1);
            chk("t2_head", o_head, exp_head(8'(8 * (c - 1)), c - 1));
            chk("t2_meta", o_meta, (MW'(c - 1) << 32) | fld(8'(8 * (c - 1)), c - 1));
         end
      end
      tick();
      chk("t2_drain", o_valid, 1'b0);

      // Backpressure: two beats fill the pipe, third waits.
      i_ready = 1'b0;
      set_beat(8'h40, key(1, 0), '0, '0, '0, 1, 0, '0);
      i_valid = 1'b1;
      chk("t3_ready_a", o_ready, 1'b1);
      tick();
      chk("t3_ready_b", o_ready, 1'b1);
      set_beat(8'h80, key(1, 0), '0, '0, '0, 1, 0, '0);
      tick();
      chk("t3_full_ready", o_ready, 1'b0);
      chk("t3_full_valid", o_valid, 1'b1);
      set_beat(8'hC0, key(1, 0), '0, '0, '0, 1, 0, '0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("t3_hold_ready", o_ready, 1'b0);
         chk("t3_hold_head", o_head, exp_head(8'h40, 1));
         chk("t3_hold_meta", o_meta, 256'h4041);
      end
      i_ready = 1'b1;
      #1;
      chk("t3_release_ready", o_ready, 1'b1);
      tick();
      i_valid = 1'b0;
      chk("t3_b_valid", o_valid, 1'b1);
      chk("t3_b_head", o_head, exp_head(8'h80, 1));
      chk("t3_b_meta", o_meta, 256'h8081);
      tick();
      chk("t3_c_valid", o_valid, 1'b1);
      chk("t3_c_head", o_head, exp_head(8'hC0, 1));
      chk("t3_c_meta", o_meta, 256'hC0C1);
      tick();
      chk("t3_drain", o_valid, 1'b0);

      // Full-width shifts leave only key slots.
      set_beat(8'h00, key(1, 0), '0, key(1, 5), '0, 64, 16, '1);
      i_valid = 1'b1;
      tick();
      i_valid = 1'b0;
      tick();
      chk("t4_valid", o_valid, 1'b1);
      chk("t4_head", o_head, '0);
      chk("t4_meta", o_meta, 256'h0506_0000_0001);
      tick();

      // Offset boundary: 62 is in range, 63 wraps or errors.
      set_beat(8'h00, key(1, 62), key(1, 63), '0, '0, 0, 0, '0);
      i_valid = 1'b1;
      tick();
      i_valid = 1'b0;
      tick();
      chk("t5_valid", o_valid, 1'b1);
      chk("t5_head", o_head, mk_head(8'h00));
`ifdef OFFSET_CHECK_EN
      chk("t5_meta", o_meta, 256'h3E3F);
      chk("t5_err", o_err, 1'b1);
`else
      chk("t5_meta", o_meta, 256'h3F00_3E3F);
      chk("t5_err", o_err, 1'b0);
`endif
      tick();

      // Reset with both stages full.
      i_ready = 1'b0;
      set_beat(8'h10, key(1, 2), '0, '0, '0, 3, 2, 256'hABCD);
      i_valid = 1'b1;
      tick();
      tick();
      chk("t6_full_valid", o_valid, 1'b1);
      chk("t6_full_ready", o_ready, 1'b0);
      chk("t6_full_meta", o_meta, 256'hABCD_0000_1213);
      chk("t6_full_head", o_head, exp_head(8'h10, 3));
      #2;
      i_rst = 1'b1;
      #1;
      chk("t6_rst_valid", o_valid, 1'b0);
      chk("t6_rst_ready", o_ready, 1'b1);
      chk("t6_rst_head", o_head, '0);
      chk("t6_rst_meta", o_meta, '0);
      chk("t6_rst_err", o_err, 1'b0);
      i_valid = 1'b0;
      i_ready = 1'b1;
      @(negedge i_clk);
      i_rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("t6_after_rst", o_valid, 1'b0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
